fetch_queue: RTL
================

# fetch_queue

Instruction queue between the instruction-fetch stage and decode. It captures each fetched instruction/PC pair on the fetch stage's one-cycle `valid` pulse and buffers up to DEPTH entries. Entries are presented to decode under a valid/ready handshake. The block also handles pipeline redirects: on `flush` it empties the queue and discards the stale response of any fetch still in flight.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-low (state clears on the rising edge of clk while rst==0).
- in_valid  in  1  one-cycle pulse from fetch: a completed instruction is present.
- in_inst  in  inst_t  fetched instruction.
- in_pc  in  addr_t  PC of in_inst.
- fetch_awaiting  in  1  fetch stage has an outstanding bus request.
- flush  in  1  redirect: discard all queued and in-flight instructions.
- out_valid  out  1  head entry is valid.
- out_inst  out  inst_t  head instruction.
- out_pc  out  addr_t  head PC.
- out_ready  in  1  decode accepts the head this cycle.
- almost_full  out  1  count ≥ DEPTH-1; upstream must not issue a new fetch while high.
- count  out  $clog2(DEPTH+1)  occupied entries.
- overflow  out  1  sticky error: a push was dropped because the queue was full.

## Operation
- Storage: DEPTH × fetch_entry_t, with rd_ptr and wr_ptr of $clog2(DEPTH) bits each. Pointers wrap modulo DEPTH.
- pop = out_valid & out_ready.
- push = in_valid & ~flush & (state==RUN) & (count<DEPTH | pop).
- count_next = count + push − pop.
- out_valid = (count != 0). out_inst/out_pc = entry[rd_ptr], combinational from storage.
- Full with simultaneous push and pop: both happen and count stays at DEPTH.
- Dropped arrival: in_valid while full with no pop, in RUN and without flush. The entry is not written and overflow sets, holding until reset.
- Empty with out_ready high: no pop and no state change.
- State machine:
  - RUN (reset state): normal push/pop.
  - DRAIN: discard the next in_valid; no push in this state.
- Transitions:
  - flush in any state: count←0, rd_ptr←wr_ptr←0, no pop. Next state is DRAIN if fetch_awaiting==1 in that cycle, otherwise RUN. An in_valid in the flush cycle is discarded and does not by itself keep the block in DRAIN.
  - DRAIN & in_valid & ~flush → RUN; the arrival is discarded.
  - DRAIN without in_valid: stay in DRAIN.
  - flush during DRAIN: re-evaluated by the flush rule above.
- Flush has priority over push, pop and the DRAIN exit.

## Timing
- Reset (rst==0 at a clk edge):
  - state←RUN, pointers←0, count←0, overflow←0.
  - All storage entries←0, so out_inst=0 and out_pc=0.
  - out_valid=0 and almost_full=0 in the cycle after reset.
- Reset asserted mid-operation has the same effect and wins over flush, push and pop.
- Push latency: an in_valid at edge t makes the entry visible on out_* and count after edge t. There is no same-cycle bypass; minimum fetch-to-decode latency is 1 cycle.
- Pop: the head advances at the edge where out_valid & out_ready. The next entry appears in the same cycle the pop is registered.
- almost_full, count and overflow are derived from registered state with no combinational path from in_valid.
- Flush: out_valid=0 from the cycle after the flush edge.

## Structure
- Add to the shared `common` package: `typedef struct packed { inst_t inst; addr_t pc; } fetch_entry_t;`.
- Reuse the existing `inst_t`, `addr_t` and `bool` types from `common`.
- The state enum (RUN, DRAIN) is local to the block.
- Single module, no sub-modules. Storage is an in-module register array; no SRAM macro.

## Test plan
- Reset, then 3 pushes with pc=0x8000_0000/04/08 and out_ready=0 → count=3, almost_full=1, out_pc=0x8000_0000. Then out_ready=1 for 3 cycles → pcs pop in order, and count=0 and out_valid=0 after the third pop.
- Fill DEPTH=4, then push pc=0x8000_0010 with out_ready=0 → entry dropped, count=4, overflow=1 and stays 1 through later pushes and pops. Push and pop in the same cycle while full → count stays 4 and FIFO order is preserved across the pointer wrap.
- 2 entries queued, flush with fetch_awaiting=1 → count=0, out_valid=0 the next cycle. The next in_valid (pc=0x8000_0100) is discarded. The following in_valid (pc=0x8000_0200) is pushed and appears on out_pc.
- Flush with fetch_awaiting=0 and a simultaneous in_valid → that arrival is discarded, state=RUN, and the next in_valid is accepted.
- Assert rst=0 mid-stream with 3 entries, then release → count=0, out_valid=0, out_inst=0, out_pc=0, overflow=0, state=RUN. An in_valid 1 cycle after release is queued normally.
- Random in_valid/out_ready/flush traffic against a scoreboard model for 10k cycles → no reordering, no duplication, no lost entries except the specified drops.

Source files
------------

// File: rtl/common.sv
// Shared pipeline types used across the core front end.
package common;

    typedef logic        bool;
    typedef logic [31:0] inst_t;
    typedef logic [31:0] addr_t;

    typedef struct packed {
        inst_t inst;
        addr_t pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode, with flush handling that
// also discards the stale response of a fetch still in flight.
module fetch_queue
    import common::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  bool                        in_valid,
    input  inst_t                      in_inst,
    input  addr_t                      in_pc,
    input  bool                        fetch_awaiting,
    input  bool                        flush,
    output bool                        out_valid,
    output inst_t                      out_inst,
    output addr_t                      out_pc,
    input  bool                        out_ready,
    output bool                        almost_full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output bool                        overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {StRun, StDrain} state_e;

    state_e          state_q;
    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] count_q;
    bool             overflow_q;

    bool full;
    bool pop;
    bool push;
    bool drop;

    assign full      = (count_q == CntW'(DEPTH));
    assign out_valid = (count_q != '0);
    // Pop is gated by flush here so the datapath never advances in a flush cycle.
    assign pop       = out_valid & out_ready & ~flush;
    assign push      = in_valid & ~flush & (state_q == StRun) & (~full | pop);
    assign drop      = in_valid & ~flush & (state_q == StRun) & full & ~pop;

    assign out_inst    = mem_q[rd_ptr_q].inst;
    assign out_pc      = mem_q[rd_ptr_q].pc;
    assign almost_full = (count_q >= CntW'(DEPTH - 1));
    assign count       = count_q;
    assign overflow    = overflow_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StRun;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            // An outstanding request will still return; its data must be swallowed.
            state_q  <= fetch_awaiting ? StDrain : StRun;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{inst: in_inst, pc: in_pc};
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (state_q == StDrain && in_valid) begin
                state_q <= StRun;
            end
        end
    end

endmodule
